// File: rtl/ascon_permutation_ti_unrolled.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ascon_permutation_ti_unrolled                                |
// | Description : 3-share threshold-implementation Ascon permutation, UNROLL   |
// |               rounds per randomness beat, start/done/ack handshake.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ascon_permutation_ti_unrolled #(
    parameter int UNROLL       = 1,
    parameter int CLEAR_ON_ACK = 1,
    parameter int RAND_W       = 448
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic [3:0]               rounds_i,
    input  logic [319:0]             s0_i,
    input  logic [319:0]             s1_i,
    input  logic [319:0]             s2_i,
    output logic                     ready_o,
    input  logic [UNROLL*RAND_W-1:0] rand_i,
    input  logic                     rand_valid_i,
    output logic                     rand_ready_o,
    output logic [319:0]             out_0,
    output logic [319:0]             out_1,
    output logic [319:0]             out_2,
    output logic                     done_o,
    input  logic                     ack_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam logic [3:0] c_step = 4'(UNROLL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [319:0] r_s0, r_s1, r_s2;
    logic [3:0]   r_ctr;
    logic [3:0]   r_rounds;
    logic         r_done, r_err, r_ready, r_run;
    logic         w_legal;
    logic [959:0] w_next;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One masked round on {share0, share1, share2}; no step ever combines two
    // shares of the same variable except inside a non-complete AND term.
    function automatic logic [959:0] ti_round(input logic [959:0] st,
                                              input logic [RAND_W-1:0] rnd,
                                              input logic [7:0] rc);
        logic [63:0]  x [3][5];
        logic [63:0]  y [3][5];
        logic [63:0]  a [3];
        logic [63:0]  b [3];
        logic [63:0]  r5, r6;
        logic [959:0] res;
        for (int s = 0; s < 3; s++)
            for (int j = 0; j < 5; j++)
                x[s][j] = st[959 - 320*s - 64*j -: 64];
        r5 = rnd[5*64 +: 64];
        r6 = rnd[6*64 +: 64];
        x[0][2] ^= r5;
        x[1][2] ^= r6;
        x[2][2] ^= r5 ^ r6 ^ {56'd0, rc};
        for (int s = 0; s < 3; s++) begin
            x[s][0] ^= x[s][4];
            x[s][4] ^= x[s][3];
            x[s][2] ^= x[s][1];
        end
        // chi: y_i = x_i ^ (~x_{i+1} & x_{i+2}), inversion carried by share 0
        for (int i = 0; i < 5; i++) begin
            for (int s = 0; s < 3; s++) begin
                a[s] = x[s][(i+1)%5];
                b[s] = x[s][(i+2)%5];
            end
            a[0] = ~a[0];
            y[0][i] = x[0][i] ^ (a[1] & b[1]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
            y[1][i] = x[1][i] ^ (a[2] & b[2]) ^ (a[2] & b[0]) ^ (a[0] & b[2]);
            y[2][i] = x[2][i] ^ (a[0] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
        end
        for (int s = 0; s < 3; s++) begin
            y[s][1] ^= y[s][0];
            y[s][0] ^= y[s][4];
            y[s][3] ^= y[s][2];
        end
        y[0][2] = ~y[0][2];
        for (int s = 0; s < 3; s++) begin
            x[s][0] = y[s][0] ^ ror64(y[s][0], 19) ^ ror64(y[s][0], 28);
            x[s][1] = y[s][1] ^ ror64(y[s][1], 61) ^ ror64(y[s][1], 39);
            x[s][2] = y[s][2] ^ ror64(y[s][2], 1)  ^ ror64(y[s][2], 6);
            x[s][3] = y[s][3] ^ ror64(y[s][3], 10) ^ ror64(y[s][3], 17);
            x[s][4] = y[s][4] ^ ror64(y[s][4], 7)  ^ ror64(y[s][4], 41);
        end
        for (int j = 0; j < 5; j++) begin
            x[0][j] ^= rnd[64*j +: 64];
            x[2][j] ^= rnd[64*j +: 64];
        end
        for (int s = 0; s < 3; s++)
            for (int j = 0; j < 5; j++)
                res[959 - 320*s - 64*j -: 64] = x[s][j];
        return res;
    endfunction

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [959:0] w_in, w_out;
        logic [3:0]   w_idx;
        logic [7:0]   w_rc;
        if (k == 0) begin : g_first
            assign w_in = {r_s0, r_s1, r_s2};
        end else begin : g_next
            assign w_in = g_round[k-1].w_out;
        end
        assign w_idx = 4'd12 - r_rounds + r_ctr + 4'(k);
        assign w_rc  = {4'hF - w_idx, w_idx};
        assign w_out = ti_round(w_in, rand_i[k*RAND_W +: RAND_W], w_rc);
    end

    assign w_next  = g_round[UNROLL-1].w_out;
    assign w_legal = (rounds_i == 4'd12) || (rounds_i == 4'd8) || (rounds_i == 4'd6);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_s0     <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_ctr    <= '0;
            r_rounds <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b1;
            r_run    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_legal) begin
                            r_s0     <= s0_i;
                            r_s1     <= s1_i;
                            r_s2     <= s2_i;
                            r_rounds <= rounds_i;
                            r_ctr    <= '0;
                            r_state  <= S_RUN;
                            r_ready  <= 1'b0;
                            r_run    <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (rand_valid_i) begin
                        {r_s0, r_s1, r_s2} <= w_next;
                        r_ctr <= r_ctr + c_step;
                        if (r_ctr + c_step == r_rounds) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_run   <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (ack_i) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                        if (CLEAR_ON_ACK != 0) begin
                            r_s0 <= '0;
                            r_s1 <= '0;
                            r_s2 <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_run   <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out_0        = r_s0;
    assign out_1        = r_s1;
    assign out_2        = r_s2;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign ready_o      = r_ready;
    assign busy_o       = ~r_ready;
    assign rand_ready_o = r_run;

endmodule
`default_nettype wire

// File: tb/tb_ascon_permutation_ti_unrolled.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ascon_permutation_ti_unrolled                             |
// | Description : UNROLL=1 and UNROLL=2 instances in lockstep against an       |
// |               unmasked table-driven Ascon model.                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ascon_permutation_ti_unrolled;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start, rvalid, ack;
    logic [3:0]   rounds;
    logic [319:0] s0, s1, s2;
    logic [895:0] rnd;
    bit           zero_rand;

    logic         rdy [2];
    logic         rrdy [2];
    logic         done [2];
    logic         busy [2];
    logic         err [2];
    logic [319:0] o0 [2];
    logic [319:0] o1 [2];
    logic [319:0] o2 [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ascon_permutation_ti_unrolled #(.UNROLL(1), .CLEAR_ON_ACK(1), .RAND_W(448)) u1 (
        .clk(clk), .reset_n(reset_n), .start_i(start), .rounds_i(rounds),
        .s0_i(s0), .s1_i(s1), .s2_i(s2), .ready_o(rdy[0]),
        .rand_i(rnd[447:0]), .rand_valid_i(rvalid), .rand_ready_o(rrdy[0]),
        .out_0(o0[0]), .out_1(o1[0]), .out_2(o2[0]), .done_o(done[0]),
        .ack_i(ack), .busy_o(busy[0]), .err_o(err[0]));

    ascon_permutation_ti_unrolled #(.UNROLL(2), .CLEAR_ON_ACK(1), .RAND_W(448)) u2 (
        .clk(clk), .reset_n(reset_n), .start_i(start), .rounds_i(rounds),
        .s0_i(s0), .s1_i(s1), .s2_i(s2), .ready_o(rdy[1]),
        .rand_i(rnd), .rand_valid_i(rvalid), .rand_ready_o(rrdy[1]),
        .out_0(o0[1]), .out_1(o1[1]), .out_2(o2[1]), .done_o(done[1]),
        .ack_i(ack), .busy_o(busy[1]), .err_o(err[1]));

    // ---------------- unmasked reference ----------------
    function automatic logic [4:0] sbox(input logic [4:0] v);
        case (v)
            5'h00: return 5'h04; 5'h01: return 5'h0b; 5'h02: return 5'h1f; 5'h03: return 5'h14;
            5'h04: return 5'h1a; 5'h05: return 5'h15; 5'h06: return 5'h09; 5'h07: return 5'h02;
            5'h08: return 5'h1b; 5'h09: return 5'h05; 5'h0a: return 5'h08; 5'h0b: return 5'h12;
            5'h0c: return 5'h1d; 5'h0d: return 5'h03; 5'h0e: return 5'h06; 5'h0f: return 5'h1c;
            5'h10: return 5'h1e; 5'h11: return 5'h13; 5'h12: return 5'h07; 5'h13: return 5'h0e;
            5'h14: return 5'h00; 5'h15: return 5'h0d; 5'h16: return 5'h11; 5'h17: return 5'h18;
            5'h18: return 5'h10; 5'h19: return 5'h0c; 5'h1a: return 5'h01; 5'h1b: return 5'h19;
            5'h1c: return 5'h16; 5'h1d: return 5'h0a; 5'h1e: return 5'h0f; default: return 5'h17;
        endcase
    endfunction

    function automatic logic [7:0] rc_tab(input int idx);
        logic [95:0] t;
        t = 96'hf0e1d2c3b4a5968778695a4b;
        return t[95 - 8*idx -: 8];
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] sbox_layer(input logic [319:0] st);
        logic [319:0] r;
        logic [4:0]   v;
        r = st;
        for (int b = 0; b < 64; b++) begin
            v = sbox({st[256+b], st[192+b], st[128+b], st[64+b], st[b]});
            {r[256+b], r[192+b], r[128+b], r[64+b], r[b]} = v;
        end
        return r;
    endfunction

    function automatic logic [319:0] lin(input logic [319:0] st);
        logic [63:0] x0, x1, x2, x3, x4;
        {x0, x1, x2, x3, x4} = st;
        return {x0 ^ ror(x0, 19) ^ ror(x0, 28), x1 ^ ror(x1, 61) ^ ror(x1, 39),
                x2 ^ ror(x2, 1)  ^ ror(x2, 6),  x3 ^ ror(x3, 10) ^ ror(x3, 17),
                x4 ^ ror(x4, 7)  ^ ror(x4, 41)};
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] st, input int nr);
        logic [319:0] s;
        s = st;
        for (int i = 0; i < nr; i++) begin
            s[135:128] = s[135:128] ^ rc_tab(12 - nr + i);
            s = lin(sbox_layer(s));
        end
        return s;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle model and compare ----------------
    int           mst [2];
    int           beats [2];
    int           nr [2];
    bit           eerr [2];
    logic [319:0] gold [2];
    logic [319:0] p0 [2];
    logic [319:0] p1 [2];
    logic [319:0] p2 [2];

    initial for (int k = 0; k < 2; k++) begin
        mst[k] = 0; beats[k] = 0; nr[k] = 0; eerr[k] = 0;
        gold[k] = '0; p0[k] = '0; p1[k] = '0; p2[k] = '0;
    end

    always @(posedge clk) begin : mon
        logic         st, v, a, rn;
        logic [3:0]   rd;
        logic [319:0] sx, ox;
        bit           ld, stl, clr;
        string        tg;
        st = start; v = rvalid; a = ack; rd = rounds; rn = reset_n;
        sx = s0 ^ s1 ^ s2;
        #1;
        for (int k = 0; k < 2; k++) begin
            ld = 0; stl = 0; clr = 0;
            tg = $sformatf("u%0d", k + 1);
            if (!rn) begin
                mst[k] = 0; eerr[k] = 0; clr = 1;
            end else begin
                eerr[k] = 0;
                case (mst[k])
                    0: if (st) begin
                        if (rd == 4'd12 || rd == 4'd8 || rd == 4'd6) begin
                            mst[k] = 1; nr[k] = int'(rd); beats[k] = 0; ld = 1;
                            gold[k] = perm(sx, int'(rd));
                        end else begin
                            eerr[k] = 1;
                        end
                    end
                    1: if (v) begin
                        beats[k] += k + 1;
                        if (beats[k] == nr[k]) mst[k] = 2;
                    end else begin
                        stl = 1;
                    end
                    default: if (a) begin
                        mst[k] = 0; clr = 1;
                    end
                endcase
            end
            chk({tg, " ready"}, 320'(rdy[k]), 320'(mst[k] == 0));
            chk({tg, " busy"},  320'(busy[k]), 320'(mst[k] != 0));
            chk({tg, " rand_ready"}, 320'(rrdy[k]), 320'(mst[k] == 1));
            chk({tg, " done"},  320'(done[k]), 320'(mst[k] == 2));
            chk({tg, " err"},   320'(err[k]), 320'(eerr[k]));
            ox = o0[k] ^ o1[k] ^ o2[k];
            if (ld) chk({tg, " load_xor"}, ox, sx);
            if (mst[k] == 2) chk({tg, " result_xor"}, ox, gold[k]);
            if (stl) chk({tg, " stall_freeze"}, {o0[k] ^ p0[k]} | {o1[k] ^ p1[k]} | {o2[k] ^ p2[k]}, 320'd0);
            if (clr) chk({tg, " cleared"}, o0[k] | o1[k] | o2[k], 320'd0);
            p0[k] = o0[k]; p1[k] = o1[k]; p2[k] = o2[k];
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (zero_rand) rnd = '0;
        else for (int i = 0; i < 28; i++) rnd[32*i +: 32] = $urandom;
    endtask

    task automatic run_perm(input logic [3:0] rd, input int stall_at, input int stall_len,
                            input bit zst, input int ack_delay, input bit hold);
        int lat [2];
        int cyc, dcnt;
        logic [319:0] sv;
        tick();
        start = 1'b1; rounds = rd; rvalid = 1'b1;
        if (zst) begin
            s0 = '0; s1 = '0; s2 = '0;
        end else begin
            sv = rand320(); s0 = rand320(); s1 = rand320(); s2 = sv ^ s0 ^ s1;
        end
        tick();
        if (!hold) start = 1'b0;
        lat[0] = -1; lat[1] = -1; cyc = 0;
        while ((lat[0] < 0 || lat[1] < 0) && cyc < 100) begin
            if (cyc == stall_at) rvalid = 1'b0;
            if (cyc == stall_at + stall_len) rvalid = 1'b1;
            tick();
            cyc++;
            for (int k = 0; k < 2; k++) if (lat[k] < 0 && done[k]) lat[k] = cyc;
        end
        rvalid = 1'b1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("latency p%0d u%0d", rd, k + 1), 320'(lat[k]),
                320'(int'(rd) / (k + 1) + (stall_at >= 0 ? stall_len : 0)));
        dcnt = 1;
        repeat (ack_delay) begin
            tick();
            if (done[0]) dcnt++;
        end
        chk("done_hold u1", 320'(dcnt), 320'(ack_delay + 1));
        ack = 1'b1; start = 1'b0;
        tick();
        ack = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; ack = 1'b0; rvalid = 1'b0; rounds = '0;
        s0 = '0; s1 = '0; s2 = '0; rnd = '0; zero_rand = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        chk("pin sbox(0)", sbox_layer(320'd0), {128'd0, {64{1'b1}}, 128'd0});
        chk("pin sbox(x4)", sbox_layer({256'd0, {64{1'b1}}}),
            {64'd0, {64{1'b1}}, 64'd0, {64{1'b1}}, {64{1'b1}}});
        chk("pin sigma0", lin({64'd1, 256'd0}), {64'h0000201000000001, 256'd0});
        chk("pin sigma2", lin({128'd0, 64'd1, 128'd0}), {128'd0, 64'h8400000000000001, 128'd0});

        zero_rand = 1;
        run_perm(4'd12, -1, 0, 1'b1, 1, 1'b0);
        zero_rand = 0;

        for (int i = 0; i < 3; i++) begin
            run_perm(4'd8, -1, 0, 1'b0, 1, 1'b0);
            run_perm(4'd6, -1, 0, 1'b0, 1, 1'b0);
        end

        run_perm(4'd12, 2, 5, 1'b0, 1, 1'b0);

        tick();
        start = 1'b1; rounds = 4'd7;
        tick();
        start = 1'b0;
        chk("illegal err u1", 320'(err[0]), 320'd1);
        chk("illegal ready u1", 320'(rdy[0]), 320'd1);
        tick();
        chk("illegal err pulse u1", 320'(err[0]), 320'd0);
        run_perm(4'd12, -1, 0, 1'b0, 1, 1'b0);

        run_perm(4'd12, -1, 0, 1'b0, 3, 1'b1);

        tick();
        start = 1'b1; rounds = 4'd12; rvalid = 1'b1;
        s0 = rand320(); s1 = rand320(); s2 = rand320();
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort shares u%0d", k + 1), o0[k] | o1[k] | o2[k], 320'd0);
            chk($sformatf("abort done u%0d", k + 1), 320'(done[k]), 320'd0);
            chk($sformatf("abort ready u%0d", k + 1), 320'(rdy[k]), 320'd1);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_perm(4'd12, -1, 0, 1'b0, 1, 1'b0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
